video_source_scheduler: RTL and testbench

// Generates 720x480p60 raster timing in the 27 MHz pixel domain and shares the DVI TX between two pixel sources:
// src0 = test-pattern generator, src1 = CV pipeline. Source ownership changes only at frame boundaries.

---
 rtl/video_source_scheduler.sv | 131 +++++++++++++
 tb/tb_video_source_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/video_source_scheduler.sv
// Raster timing generator for the DVI TX that hands the pixel stream to one of two
// sources, switching owners only between frames.
module video_source_scheduler #(
  parameter int unsigned H_ACTIVE = 720,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 62,
  parameter int unsigned H_BP     = 60,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 9,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 30,
  parameter logic        SYNC_POL = 1'b0,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        src0_req,
  input  logic        src1_req,
  input  logic [23:0] src0_rgb,
  input  logic [23:0] src1_rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [1:0]  pix_rd,
  output logic [1:0]  grant,
  output logic        frame_start,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic        rgb_hs,
  output logic        rgb_vs,
  output logic        rgb_de
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_W  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_W  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [1:0]    grant_q, grant_d;
  logic          s1_active_q, s1_hs_q, s1_vs_q;
  logic [1:0]    s1_grant_q;
  logic          de_q, hs_q, vs_q;
  logic [23:0]   rgb_q, rgb_d;

  logic line_last_c, frame_last_c, active_c, hs_lvl_c, vs_lvl_c;
  logic [23:0] src_sel_c;

  // Raster counters, sync levels and the frame-boundary grant decision
  always_comb begin
    line_last_c  = (h_q == H_LAST);
    frame_last_c = line_last_c && (v_q == V_LAST);
    active_c     = (h_q < H_ACT_W) && (v_q < V_ACT_W);
    hs_lvl_c     = ((h_q >= HS_START) && (h_q <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_lvl_c     = ((v_q >= VS_START) && (v_q <= VS_END)) ? SYNC_POL : ~SYNC_POL;

    h_d = line_last_c ? '0 : h_q + CW'(1);
    v_d = v_q;
    if (line_last_c) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
    end

    grant_d = grant_q;
    if (frame_last_c) begin
      if (src1_req)      grant_d = 2'b10;
      else if (src0_req) grant_d = 2'b01;
      else               grant_d = 2'b00;
    end
  end

  // Stage-1 grant picks which source's returning data lands on the output
  always_comb begin
    case (s1_grant_q)
      2'b10:   src_sel_c = src1_rgb;
      2'b01:   src_sel_c = src0_rgb;
      default: src_sel_c = FILL_RGB;
    endcase
    rgb_d = s1_active_q ? src_sel_c : 24'h000000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q         <= '0;
      v_q         <= '0;
      grant_q     <= 2'b00;
      s1_active_q <= 1'b0;
      s1_hs_q     <= ~SYNC_POL;
      s1_vs_q     <= ~SYNC_POL;
      s1_grant_q  <= 2'b00;
      de_q        <= 1'b0;
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
      rgb_q       <= 24'h000000;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      grant_q     <= grant_d;
      s1_active_q <= active_c;
      s1_hs_q     <= hs_lvl_c;
      s1_vs_q     <= vs_lvl_c;
      s1_grant_q  <= grant_q;
      de_q        <= s1_active_q;
      hs_q        <= s1_hs_q;
      vs_q        <= s1_vs_q;
      rgb_q       <= rgb_d;
    end
  end

  // Strobes are decoded from the live counters and held off while reset is high
  assign pix_rd      = rst ? 2'b00 : (grant_q & {2{active_c}});
  assign frame_start = ~rst && (h_q == '0) && (v_q == '0);

  assign pix_x  = h_q;
  assign pix_y  = v_q;
  assign grant  = grant_q;
  assign rgb_r  = rgb_q[23:16];
  assign rgb_g  = rgb_q[15:8];
  assign rgb_b  = rgb_q[7:0];
  assign rgb_hs = hs_q;
  assign rgb_vs = vs_q;
  assign rgb_de = de_q;

endmodule

// File: tb/tb_video_source_scheduler.sv
// Scoreboard bench for video_source_scheduler on a shrunken 16x11 raster so
// several whole frames fit in a short run.
module tb_video_source_scheduler;

  localparam int HA = 8, HF = 2, HSY = 3, HB = 3;
  localparam int VA = 6, VF = 1, VSY = 2, VB = 2;
  localparam int HT = 16, VT = 11, FRAME = 176;
  localparam int HS_LO = 10, HS_HI = 12, VS_LO = 7, VS_HI = 8;
  localparam logic [23:0] FILL = 24'h00FF00;

  logic        clk = 1'b0;
  logic        rst, src0_req, src1_req;
  logic [23:0] src0_rgb, src1_rgb;
  logic [9:0]  pix_x, pix_y;
  logic [1:0]  pix_rd, grant;
  logic        frame_start;
  logic [7:0]  rgb_r, rgb_g, rgb_b;
  logic        rgb_hs, rgb_vs, rgb_de;

  video_source_scheduler #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .SYNC_POL(1'b0), .FILL_RGB(FILL)
  ) dut (
    .clk(clk), .rst(rst), .src0_req(src0_req), .src1_req(src1_req),
    .src0_rgb(src0_rgb), .src1_rgb(src1_rgb), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rd(pix_rd), .grant(grant), .frame_start(frame_start),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .rgb_hs(rgb_hs), .rgb_vs(rgb_vs), .rgb_de(rgb_de)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [1:0]  rd;
    logic [1:0]  g;
    logic        fs;
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [23:0] f0(int x, int y);
    return {8'h40, 8'(x), 8'(y)};
  endfunction

  function automatic logic [23:0] f1(int x, int y);
    return 24'h800000 | 24'(x * y);
  endfunction

  // Source models: return pattern data one cycle after the coordinates
  initial begin
    logic [9:0] cx, cy;
    src0_rgb = '0;
    src1_rgb = '0;
    forever begin
      @(negedge clk);
      cx = pix_x;
      cy = pix_y;
      @(posedge clk);
      #1;
      src0_rgb = f0(int'(cx), int'(cy));
      src1_rgb = f1(int'(cx), int'(cy));
    end
  end

  // Reference model: raster position, frame-boundary grant, 2-cycle output latency
  initial begin
    int mh, mv, ncyc;
    logic [1:0] mg;
    int h1, v1, h2, v2;
    logic [1:0] g1, g2;
    logic r1, r2, r, a, a2;
    exp_t e;
    mh = 0; mv = 0; mg = 2'b00; ncyc = 0;
    h1 = 0; v1 = 0; h2 = 0; v2 = 0; g1 = 2'b00; g2 = 2'b00; r1 = 1'b1; r2 = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      r = rst;
      a = (mh < HA) && (mv < VA);
      e.x  = 10'(mh);
      e.y  = 10'(mv);
      e.g  = mg;
      e.rd = (r || !a) ? 2'b00 : mg;
      e.fs = !r && (mh == 0) && (mv == 0);
      if (r1 || r2) begin
        e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.rgb = 24'h000000;
      end else begin
        a2   = (h2 < HA) && (v2 < VA);
        e.de = a2;
        e.hs = !((h2 >= HS_LO) && (h2 <= HS_HI));
        e.vs = !((v2 >= VS_LO) && (v2 <= VS_HI));
        if (!a2)               e.rgb = 24'h000000;
        else if (g2 == 2'b10)  e.rgb = f1(h2, v2);
        else if (g2 == 2'b01)  e.rgb = f0(h2, v2);
        else                   e.rgb = FILL;
      end
      if (ncyc >= 2) exp_q.push_back(e);
      h2 = h1; v2 = v1; g2 = g1; r2 = r1;
      h1 = mh; v1 = mv; g1 = mg; r1 = r;
      if (r) begin
        mh = 0; mv = 0; mg = 2'b00;
      end else begin
        if (mh == HT - 1 && mv == VT - 1) mg = src1_req ? 2'b10 : (src0_req ? 2'b01 : 2'b00);
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
      ncyc++;
    end
  end

  // Monitor: pops one expectation per output cycle
  initial begin
    exp_t act, e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = '{x: pix_x, y: pix_y, rd: pix_rd, g: grant, fs: frame_start,
                de: rgb_de, hs: rgb_hs, vs: rgb_vs, rgb: {rgb_r, rgb_g, rgb_b}};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL cycle_out t=%0t act x=%0d y=%0d rd=%b g=%b fs=%b de=%b hs=%b vs=%b rgb=%h | exp x=%0d y=%0d rd=%b g=%b fs=%b de=%b hs=%b vs=%b rgb=%h",
                   $time, act.x, act.y, act.rd, act.g, act.fs, act.de, act.hs, act.vs, act.rgb,
                   e.x, e.y, e.rd, e.g, e.fs, e.de, e.hs, e.vs, e.rgb);
        end
      end
    end
  end

  // Per-frame totals between consecutive frame_start pulses on an undisturbed raster
  initial begin
    int cyc, last_fs, de_cnt, hs_cnt, vs_cnt;
    bit clean;
    cyc = 0; last_fs = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; clean = 0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (rst === 1'b1) begin
        clean = 0;
      end else if (frame_start === 1'b1) begin
        if (clean) begin
          checks += 4;
          if (cyc - last_fs != FRAME) begin
            failures++; $display("FAIL frame_len act=%0d exp=%0d", cyc - last_fs, FRAME);
          end
          if (de_cnt != HA * VA) begin
            failures++; $display("FAIL de_per_frame act=%0d exp=%0d", de_cnt, HA * VA);
          end
          if (hs_cnt != HSY * VT) begin
            failures++; $display("FAIL hs_low_per_frame act=%0d exp=%0d", hs_cnt, HSY * VT);
          end
          if (vs_cnt != VSY * HT) begin
            failures++; $display("FAIL vs_low_per_frame act=%0d exp=%0d", vs_cnt, VSY * HT);
          end
        end
        clean = 1; last_fs = cyc; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
      end
      if (rgb_de === 1'b1) de_cnt++;
      if (rgb_hs === 1'b0) hs_cnt++;
      if (rgb_vs === 1'b0) vs_cnt++;
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; src0_req = 1'b0; src1_req = 1'b0;
    run(3);
    rst = 1'b0;
    run(50);
    rst = 1'b1;                    // mid-frame reset
    run(5);
    rst = 1'b0;
    run(FRAME + 20);               // first frame: fill colour only
    src0_req = 1'b1;
    run(FRAME);                    // src0 takes over at the boundary
    run(FRAME);
    run(40);
    src1_req = 1'b1;               // mid-frame request, must wait for boundary
    run(2 * FRAME);
    src1_req = 1'b0;               // src0 returns at the next boundary
    run(2 * FRAME);
    src1_req = 1'b1;
    run(FRAME + 5 * HT);
    rst = 1'b1;                    // reset during src1 ownership
    run(3);
    rst = 1'b0;
    run(2 * FRAME + 10);
    run(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
